// File: rtl/riscv_defs.sv
// Shared RISC-V definitions: opcodes, ALU operation codes,
// controller state encoding and the decoded control bundle.
package riscv_defs;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [6:0] F7_ALT = 7'b0100000;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;
   localparam logic [3:0] ALU_XOR = 4'b0101;

   typedef enum logic [2:0] {
      S_IF,
      S_ID,
      S_EX,
      S_MEM,
      S_WB
   } state_t;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       branch;
   } dec_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of opcode/funct3/funct7 into the
// ALU operation and the per-instruction control bundle.
module alu_decoder
   import riscv_defs::*;
#(
   parameter logic [3:0] ALU_AND = riscv_defs::ALU_AND,
   parameter logic [3:0] ALU_OR  = riscv_defs::ALU_OR,
   parameter logic [3:0] ALU_ADD = riscv_defs::ALU_ADD,
   parameter logic [3:0] ALU_SUB = riscv_defs::ALU_SUB,
   parameter logic [3:0] ALU_SLT = riscv_defs::ALU_SLT,
   parameter logic [3:0] ALU_SRL = riscv_defs::ALU_SRL,
   parameter logic [3:0] ALU_SLL = riscv_defs::ALU_SLL,
   parameter logic [3:0] ALU_SRA = riscv_defs::ALU_SRA,
   parameter logic [3:0] ALU_XOR = riscv_defs::ALU_XOR
) (
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output dec_t       dec
);

   logic       is_r;
   logic       is_i;
   logic       is_lw;
   logic       is_sw;
   logic       is_beq;
   logic       alt;
   logic [3:0] arith_op;

   assign is_r   = (opcode == OP_R);
   assign is_i   = (opcode == OP_I);
   assign is_lw  = (opcode == OP_LW);
   assign is_sw  = (opcode == OP_SW);
   assign is_beq = (opcode == OP_BEQ);
   assign alt    = (funct7 == F7_ALT);

   // funct3 selects the arithmetic op; SUB exists only for R-type
   always_comb begin
      arith_op = ALU_AND;
      unique case (funct3)
         3'b000:  arith_op = (is_r && alt) ? ALU_SUB : ALU_ADD;
         3'b111:  arith_op = ALU_AND;
         3'b110:  arith_op = ALU_OR;
         3'b100:  arith_op = ALU_XOR;
         3'b010:  arith_op = ALU_SLT;
         3'b001:  arith_op = ALU_SLL;
         3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
         default: arith_op = ALU_AND;
      endcase
   end

   // opcode class picks the control bundle; unknown opcodes are NOPs
   always_comb begin
      dec        = '0;
      dec.alu_op = ALU_AND;
      unique case (1'b1)
         is_r: begin
            dec.alu_op    = arith_op;
            dec.reg_write = 1'b1;
         end
         is_i: begin
            dec.alu_op    = arith_op;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
         end
         is_lw: begin
            dec.alu_op     = ALU_ADD;
            dec.alu_src    = 1'b1;
            dec.mem_read   = 1'b1;
            dec.reg_write  = 1'b1;
            dec.mem_to_reg = 1'b1;
         end
         is_sw: begin
            dec.alu_op    = ALU_ADD;
            dec.alu_src   = 1'b1;
            dec.mem_write = 1'b1;
         end
         is_beq: begin
            dec.alu_op = ALU_SUB;
            dec.branch = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Five-state multicycle controller: IF, ID, EX, MEM, WB.
// Strobes are registered for the state being entered.
module multicycle_control
   import riscv_defs::*;
#(
   parameter logic [3:0] ALU_AND = 4'b0000,
   parameter logic [3:0] ALU_OR  = 4'b0001,
   parameter logic [3:0] ALU_ADD = 4'b0010,
   parameter logic [3:0] ALU_SUB = 4'b0110,
   parameter logic [3:0] ALU_SLT = 4'b0100,
   parameter logic [3:0] ALU_SRL = 4'b1000,
   parameter logic [3:0] ALU_SLL = 4'b1001,
   parameter logic [3:0] ALU_SRA = 4'b1010,
   parameter logic [3:0] ALU_XOR = 4'b0101
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        zero,
   output logic        ir_load,
   output logic [3:0]  alu_op,
   output logic        ALUSrc,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        MemToReg,
   output logic        loadPC,
   output logic        PCSrc
);

   state_t      state;
   logic [31:0] ir_q;
   logic        zero_q;
   dec_t        dec;

   logic        ir_load_q;
   logic [3:0]  alu_op_q;
   logic        alu_src_q;
   logic        mem_read_q;
   logic        mem_write_q;
   logic        reg_write_q;
   logic        mem_to_reg_q;
   logic        load_pc_q;
   logic        pc_src_q;

   logic        unused_ir;
   assign unused_ir = ^{ir_q[24:15], ir_q[11:7]};

   alu_decoder #(
      .ALU_AND (ALU_AND),
      .ALU_OR  (ALU_OR),
      .ALU_ADD (ALU_ADD),
      .ALU_SUB (ALU_SUB),
      .ALU_SLT (ALU_SLT),
      .ALU_SRL (ALU_SRL),
      .ALU_SLL (ALU_SLL),
      .ALU_SRA (ALU_SRA),
      .ALU_XOR (ALU_XOR)
   ) u_dec (
      .opcode (ir_q[6:0]),
      .funct3 (ir_q[14:12]),
      .funct7 (ir_q[31:25]),
      .dec    (dec)
   );

   // sequencing, IR/zero capture and strobes for the next state
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= S_IF;
         ir_q         <= '0;
         zero_q       <= 1'b0;
         ir_load_q    <= 1'b1;
         alu_op_q     <= '0;
         alu_src_q    <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         load_pc_q    <= 1'b0;
         pc_src_q     <= 1'b0;
      end else begin
         ir_load_q    <= 1'b0;
         alu_op_q     <= '0;
         alu_src_q    <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         load_pc_q    <= 1'b0;
         pc_src_q     <= 1'b0;
         unique case (state)
            S_IF: begin
               state <= S_ID;
               ir_q  <= instr;
            end
            S_ID: begin
               state     <= S_EX;
               alu_op_q  <= dec.alu_op;
               alu_src_q <= dec.alu_src;
            end
            S_EX: begin
               state       <= S_MEM;
               zero_q      <= zero;
               alu_op_q    <= alu_op_q;
               alu_src_q   <= alu_src_q;
               mem_read_q  <= dec.mem_read;
               mem_write_q <= dec.mem_write;
            end
            S_MEM: begin
               state        <= S_WB;
               alu_op_q     <= alu_op_q;
               alu_src_q    <= alu_src_q;
               reg_write_q  <= dec.reg_write;
               mem_to_reg_q <= dec.mem_to_reg;
               load_pc_q    <= 1'b1;
               pc_src_q     <= dec.branch & zero_q;
            end
            S_WB: begin
               state     <= S_IF;
               ir_load_q <= 1'b1;
            end
            default: begin
               state     <= S_IF;
               ir_load_q <= 1'b1;
            end
         endcase
      end
   end

   // reset forces every strobe low for as long as it is held
   always_comb begin
      ir_load  = rst & ir_load_q;
      alu_op   = rst ? alu_op_q : 4'b0000;
      ALUSrc   = rst & alu_src_q;
      MemRead  = rst & mem_read_q;
      MemWrite = rst & mem_write_q;
      RegWrite = rst & reg_write_q;
      MemToReg = rst & mem_to_reg_q;
      loadPC   = rst & load_pc_q;
      PCSrc    = rst & pc_src_q;
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against a
// per-instruction behavioural model of the controller.
module tb_multicycle_control;

   localparam logic [6:0] T_R   = 7'b0110011;
   localparam logic [6:0] T_I   = 7'b0010011;
   localparam logic [6:0] T_LW  = 7'b0000011;
   localparam logic [6:0] T_SW  = 7'b0100011;
   localparam logic [6:0] T_BEQ = 7'b1100011;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] instr = '0;
   logic        zero = 1'b0;
   logic        ir_load;
   logic [3:0]  alu_op;
   logic        ALUSrc;
   logic        MemRead;
   logic        MemWrite;
   logic        RegWrite;
   logic        MemToReg;
   logic        loadPC;
   logic        PCSrc;

   int          n_checks = 0;
   int          n_fail = 0;

   int          phase = 0;
   logic [31:0] m_ir = '0;
   logic        m_zq = 1'b0;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk      (clk),
      .rst      (rst),
      .instr    (instr),
      .zero     (zero),
      .ir_load  (ir_load),
      .alu_op   (alu_op),
      .ALUSrc   (ALUSrc),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .RegWrite (RegWrite),
      .MemToReg (MemToReg),
      .loadPC   (loadPC),
      .PCSrc    (PCSrc)
   );

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h",
                  tag, $time, obs, exp);
      end
   endtask

   function automatic logic [3:0] ref_alu(input logic [31:0] w);
      logic [6:0] op;
      logic [2:0] f3;
      logic       alt;
      op  = w[6:0];
      f3  = w[14:12];
      alt = (w[31:25] == 7'b0100000);
      if (op == T_LW || op == T_SW) return 4'b0010;
      if (op == T_BEQ) return 4'b0110;
      if (op != T_R && op != T_I) return 4'b0000;
      case (f3)
         3'b000: return (op == T_R && alt) ? 4'b0110 : 4'b0010;
         3'b111: return 4'b0000;
         3'b110: return 4'b0001;
         3'b100: return 4'b0101;
         3'b010: return 4'b0100;
         3'b001: return 4'b1001;
         3'b101: return alt ? 4'b1010 : 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   // {ir_load, alu_op, ALUSrc, MemRead, MemWrite,
   //  RegWrite, MemToReg, loadPC, PCSrc}
   function automatic logic [11:0] ref_out(input int p,
                                            input logic r,
                                            input logic [31:0] w,
                                            input logic zq);
      logic [6:0] op;
      logic       ex;
      logic       imm;
      op  = w[6:0];
      ex  = (p >= 2);
      imm = (op == T_I) || (op == T_LW) || (op == T_SW);
      if (!r) return 12'd0;
      return {p == 0,
              ex ? ref_alu(w) : 4'b0000,
              ex && imm,
              p == 3 && op == T_LW,
              p == 3 && op == T_SW,
              p == 4 && (op == T_R || op == T_I || op == T_LW),
              p == 4 && op == T_LW,
              p == 4,
              p == 4 && op == T_BEQ && zq};
   endfunction

   task automatic tick(input logic r, input logic [31:0] w,
                       input logic z, output logic [3:0] seen);
      logic [11:0] obs;
      @(negedge clk);
      rst   = r;
      instr = w;
      zero  = z;
      #1;
      obs = {ir_load, alu_op, ALUSrc, MemRead, MemWrite,
             RegWrite, MemToReg, loadPC, PCSrc};
      check($sformatf("out_p%0d", phase), {20'd0, obs},
            {20'd0, ref_out(phase, r, m_ir, m_zq)});
      seen = alu_op;
      if (!r) begin
         phase = 0;
         m_ir  = '0;
         m_zq  = 1'b0;
      end else begin
         if (phase == 0) m_ir = w;
         if (phase == 2) m_zq = z;
         phase = (phase + 1) % 5;
      end
   endtask

   task automatic run_instr(input logic [31:0] word, input logic z,
                            input int exp_alu, input int abort_at,
                            input logic junk);
      logic [3:0]  seen;
      logic [31:0] w;
      logic        zz;
      for (int p = 0; p < 5; p++) begin
         w  = (p == 0 || !junk) ? word : $urandom;
         zz = (p == 2) ? z : 1'($urandom);
         if (p == abort_at) begin
            tick(1'b0, w, zz, seen);
            tick(1'b0, w, zz, seen);
            return;
         end
         tick(1'b1, w, zz, seen);
         if (p == 2 && exp_alu >= 0)
            check("alu_op_ex", {28'd0, seen}, exp_alu);
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 5))
         0: w[6:0] = T_R;
         1: w[6:0] = T_I;
         2: w[6:0] = T_LW;
         3: w[6:0] = T_SW;
         4: w[6:0] = T_BEQ;
         default: ;
      endcase
      if ($urandom_range(0, 1) == 1) w[31:25] = 7'b0100000;
      else if ($urandom_range(0, 1) == 1) w[31:25] = 7'b0000000;
      if ((w[6:0] == T_R || w[6:0] == T_I) && w[14:12] == 3'b011)
         w[14:12] = 3'b000;
      return w;
   endfunction

   initial begin
      logic [3:0] seen;
      int         ab;
      for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 1'b0, seen);
      run_instr(32'h002081B3, 1'b0, 4'b0010, -1, 1'b0);
      run_instr(32'h407352B3, 1'b0, 4'b1010, -1, 1'b1);
      run_instr(32'h00A08093, 1'b0, 4'b0010, -1, 1'b1);
      run_instr(32'h00812083, 1'b0, 4'b0010, -1, 1'b1);
      run_instr(32'h00208463, 1'b1, 4'b0110, -1, 1'b0);
      run_instr(32'h00208463, 1'b0, 4'b0110, -1, 1'b0);
      run_instr(32'h0000007F, 1'b1, 4'b0000, -1, 1'b1);
      run_instr(32'h002081B3, 1'b0, 4'b0010, 4, 1'b0);
      run_instr(32'h002081B3, 1'b0, 4'b0010, -1, 1'b1);
      run_instr(32'h00112423, 1'b0, 4'b0010, 3, 1'b1);
      run_instr(32'h00112423, 1'b0, 4'b0010, -1, 1'b1);
      for (int n = 0; n < 300; n++) begin
         ab = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 4) : -1;
         run_instr(rand_instr(), 1'($urandom), ab < 0 || ab > 2 ?
                   -2 : -2, ab, 1'($urandom));
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameters ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0100, ALU_SRL=4'b1000, ALU_SLL=4'b1001, ALU_SRA=4'b1010, ALU_XOR=4'b0101, which are the ALU operation codes it drives.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-low reset.
REQ-005 instr  input  32  instruction word from instruction memory.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 ir_load  output  1  strobe that latches instr internally.
REQ-008 alu_op  output  4  ALU operation code.
REQ-009 ALUSrc  output  1  ALU operand 2 select: 0 = register, 1 = immediate.
REQ-010 MemRead, MemWrite, RegWrite, MemToReg  output  1 each  datapath strobes and selects.
REQ-011 loadPC  output  1  PC update strobe; PCSrc  output  1  PC select: 0 = PC+4, 1 = branch target.

Function
REQ-012 SHALL be a Moore FSM with states IF, ID, EX, MEM, WB.
REQ-013 Transitions: IF->ID->EX->MEM->WB->IF, unconditional, one cycle per state; every instruction takes exactly 5 cycles.
REQ-014 ir_load SHALL be 1 only in IF; instr SHALL be captured on the IF clock edge.
REQ-015 Decode SHALL use only the latched instruction; changes on instr outside IF SHALL have no effect.
REQ-016 Supported opcodes: R-type 0110011, I-ALU 0010011, LW 0000011, SW 0100011, BEQ 1100011; any other opcode is a NOP.
REQ-017 R-type/I-ALU alu_op SHALL be decoded from funct3:
- 000: ADD; SUB only for R-type with funct7=0100000.
- 111: AND. 110: OR. 100: XOR. 010: SLT. 001: SLL.
- 101: SRL, or SRA when funct7=0100000 (also for srai).
REQ-018 LW/SW SHALL drive ALU_ADD; BEQ SHALL drive ALU_SUB; NOP SHALL drive ALU_AND (0000).
REQ-019 alu_op and ALUSrc SHALL hold their decoded values in EX, MEM and WB; they are 0 in IF and ID.
REQ-020 ALUSrc SHALL be 1 for I-ALU, LW and SW, and 0 otherwise.
REQ-021 zero SHALL be registered into zero_q on the EX clock edge.
REQ-022 MEM strobes: MemRead=1 in MEM only for LW; MemWrite=1 in MEM only for SW.
REQ-023 WB strobes: RegWrite=1 in WB for R-type, I-ALU and LW; MemToReg=1 in WB for LW only.
REQ-024 loadPC SHALL be 1 in WB for every instruction, including NOPs.
REQ-025 PCSrc SHALL be 1 in WB only when the instruction is BEQ and zero_q=1.
REQ-026 All strobes not stated as 1 SHALL be 0; strobes SHALL be glitch-free decodes of registered state.

Reset
REQ-027 While rst=0 at a clock edge, state SHALL go to IF and the latched instruction and zero_q SHALL clear to 0.
REQ-028 While rst=0, all outputs SHALL be 0, including ir_load.
REQ-029 Reset in any state, including mid-instruction, SHALL abort the instruction with no further MemWrite, RegWrite or loadPC.
REQ-030 The first cycle after rst returns to 1 SHALL be IF with ir_load=1.

Structure
REQ-031 Opcode constants, ALU codes and state encodings SHALL live in the shared package riscv_defs, also used by alu.
REQ-032 funct3/funct7/opcode-to-alu_op decode SHALL be a combinational sub-module alu_decoder; the FSM stays in multicycle_control.

Verification
REQ-033 Reset: drive rst=0 for 2 cycles during WB -> all outputs 0 with no loadPC pulse; release -> next cycle IF with ir_load=1.
REQ-034 add x3,x1,x2 (0x002081B3) -> EX alu_op=0010, ALUSrc=0; WB RegWrite=1, loadPC=1, PCSrc=0; period 5 cycles.
REQ-035 sra x5,x6,x7 (0x407352B3) -> alu_op=1010; addi (0x00A08093) -> alu_op=0010, ALUSrc=1.
REQ-036 lw x1,8(x2) (0x00812083) -> alu_op=0010, ALUSrc=1; MEM MemRead=1; WB RegWrite=1, MemToReg=1.
REQ-037 beq x1,x2,8 (0x00208463), zero=1 in EX -> WB PCSrc=1, RegWrite=0; repeated with zero=0 -> PCSrc=0.
REQ-038 Illegal 0x0000007F -> alu_op=0000, no MemRead/MemWrite/RegWrite, loadPC=1 in WB; instr toggled outside IF -> no decode change.
